// File: rtl/apple1_kbd_hub_if.sv
// Source byte streams and the 6502-side KBD/KBDCR port of the Apple-1 keyboard hub.
// Handshake: a source drives src_valid/src_data and holds both stable until a clk25 edge
// at which src_valid & src_ready are both high; src_ready is combinational and may change
// at any time, and a source never waits for src_ready before raising src_valid.
interface apple1_kbd_hub_if #(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 flush;
  logic                 cs;
  logic                 enable;
  logic                 we;
  logic                 address;
  logic [7:0]           dout;
  logic                 overflow;
  logic [LVL_W-1:0]     fifo_level;

  modport master (
    output src_valid, src_data, flush, cs, enable, we, address,
    input  src_ready, dout, overflow, fifo_level
  );

  modport slave (
    input  src_valid, src_data, flush, cs, enable, we, address,
    output src_ready, dout, overflow, fifo_level
  );
endinterface

// File: rtl/apple1_kbd_hub.sv
// Apple-1 keyboard hub: round-robin merge of byte sources into a FIFO, character
// normalisation, CR pacing and PIA-style KBD/KBDCR registers.
module apple1_kbd_hub #(
  parameter int NUM_SRC        = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int CR_PACE_CYCLES = 250000,
  parameter int UPPERCASE      = 1
) (
  input  logic            clk25,
  input  logic            rst,
  apple1_kbd_hub_if.slave bus
);
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int PACE_W = (CR_PACE_CYCLES > 1) ? $clog2(CR_PACE_CYCLES + 1) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(CR_PACE_CYCLES);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] last_was_cr;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [7:0]         hold;
  logic               ready;
  logic [PACE_W-1:0]  pace_cnt;
  logic               overflow_q;
  logic [7:0]         dout_q;

  logic               full;
  logic               empty;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_SRC-1:0] src_ready_c;
  logic [7:0]         g_data;
  logic [7:0]         norm;
  logic               is_cr;
  logic               discard;
  logic               xfer;
  logic               wr_en;
  logic               wr_ok;
  logic               pop;
  logic               kbd_rd;
  int                 idx;

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  // First valid source at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!grant_any && bus.src_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  // Full FIFO withholds every ready, so sources keep their byte instead of losing it.
  always_comb begin
    src_ready_c = '0;
    if (!rst && !bus.flush && grant_any && !full) src_ready_c[grant_idx] = 1'b1;
  end

  always_comb begin
    g_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == PTR_W'(i)) g_data = bus.src_data[8*i +: 8];
    end
  end

  // Strip bit 7, fold case, then swallow the LF of a CR/LF pair and turn lone LFs into CR.
  always_comb begin
    norm = {1'b0, g_data[6:0]};
    if (UPPERCASE != 0 && norm >= 8'h61 && norm <= 8'h7A) norm = norm - 8'h20;
    is_cr   = (norm == 8'h0D);
    discard = 1'b0;
    if (norm == 8'h0A) begin
      if (last_was_cr[grant_idx]) discard = 1'b1;
      else                        norm    = 8'h0D;
    end
  end

  assign xfer   = |src_ready_c;
  assign wr_en  = xfer && !discard;
  assign wr_ok  = wr_en && !full;
  assign pop    = !ready && !empty && (pace_cnt == '0);
  assign kbd_rd = bus.cs && bus.enable && !bus.we && !bus.address;

  always_ff @(posedge clk25) begin
    if (wr_ok && !bus.flush) mem[wr_ptr] <= norm;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      last_was_cr <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      hold        <= 8'h00;
      ready       <= 1'b0;
      pace_cnt    <= '0;
      overflow_q  <= 1'b0;
      dout_q      <= 8'h00;
    end else begin
      if (bus.cs) dout_q <= bus.address ? {ready, 7'b0} : {1'b1, hold[6:0]};
      if (bus.flush) begin
        last_was_cr <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
        hold        <= 8'h00;
        ready       <= 1'b0;
        pace_cnt    <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (xfer) begin
          rr_ptr                 <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
          last_was_cr[grant_idx] <= is_cr;
        end
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (wr_en && full) overflow_q <= 1'b1;
        if (pop) begin
          hold   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + AW'(1);
        end
        level <= level + LVL_W'(wr_ok) - LVL_W'(pop);
        if (pop)                ready <= 1'b1;
        else if (kbd_rd && ready) ready <= 1'b0;
        // A consumed CR holds off the next character so the monitor can keep up.
        if (kbd_rd && ready && hold == 8'h0D) pace_cnt <= PACE_LOAD;
        else if (pace_cnt != '0)              pace_cnt <= pace_cnt - PACE_W'(1);
      end
    end
  end

  assign bus.src_ready  = src_ready_c;
  assign bus.dout       = dout_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_apple1_kbd_hub.sv
// Randomised scoreboard bench for apple1_kbd_hub: source drivers feed a character model,
// a bus monitor checks every consumed KBD byte against the expected queue.
module tb_apple1_kbd_hub;
  localparam int NS    = 3;
  localparam int DEPTH = 16;
  localparam int PACE  = 20;

  logic clk25 = 1'b0;
  logic rst;
  always #20 clk25 = ~clk25;

  apple1_kbd_hub_if #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) bus ();

  apple1_kbd_hub #(
    .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .CR_PACE_CYCLES(PACE), .UPPERCASE(1)
  ) dut (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  src_q[NS][$];
  logic [NS-1:0] last_cr;
  int          model_rr;
  int          acc_cnt;
  bit          gap_en;
  bit          ready_seen;
  int          exp_g;
  int          idx;
  logic [NS-1:0] xfer_done;
  logic        mon_addr;
  logic [7:0]  mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference character rules: 7-bit, upper case, CR/LF collapses to CR, lone LF is CR.
  function automatic void model_accept(input int g, input logic [7:0] raw);
    logic [7:0] c;
    c = raw & 8'h7F;
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    if (c == 8'h0A && last_cr[g]) begin
      last_cr[g] = 1'b0;
      return;
    end
    last_cr[g] = (c == 8'h0D);
    if (c == 8'h0A) c = 8'h0D;
    exp_q.push_back(c);
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NS; i++) n += src_q[i].size();
    return n;
  endfunction

  // ---------------- source drivers + arbitration model ----------------
  initial begin : src_driver
    bus.src_valid = '0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk25);
      xfer_done = '0;
      if (!rst && !bus.flush && bus.src_ready != '0) begin
        exp_g = -1;
        for (int k = 0; k < NS; k++) begin
          idx = (model_rr + k) % NS;
          if (exp_g < 0 && bus.src_valid[idx]) exp_g = idx;
        end
        check("grant", 32'(bus.src_ready), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
        for (int i = 0; i < NS; i++) begin
          if (bus.src_valid[i] && bus.src_ready[i]) begin
            model_accept(i, bus.src_data[8*i +: 8]);
            void'(src_q[i].pop_front());
            acc_cnt++;
            model_rr     = (i + 1) % NS;
            xfer_done[i] = 1'b1;
          end
        end
      end
      @(posedge clk25);
      #2;
      for (int i = 0; i < NS; i++) begin
        if (xfer_done[i] || !bus.src_valid[i]) begin
          if (src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            bus.src_valid[i]       = 1'b1;
            bus.src_data[8*i +: 8] = src_q[i][0];
          end else begin
            bus.src_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  initial begin : monitor
    ready_seen = 1'b0;
    forever begin
      @(posedge clk25);
      if (rst || bus.flush) begin
        ready_seen = 1'b0;
      end else if (bus.cs && bus.enable && !bus.we) begin
        mon_addr = bus.address;
        #1;
        if (mon_addr) begin
          ready_seen = bus.dout[7];
        end else if (ready_seen) begin
          ready_seen = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL kbd_unexpected actual=0x%0h expected=none", bus.dout);
          end else begin
            mon_exp = exp_q.pop_front();
            check("kbd_data", 32'(bus.dout), 32'(8'h80 | mon_exp));
          end
        end
      end
    end
  end

  // ---------------- clock/reset helpers and CPU driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] d);
    bus.cs = 1'b1; bus.enable = 1'b1; bus.we = 1'b0; bus.address = a;
    @(posedge clk25);
    #1;
    bus.cs = 1'b0; bus.enable = 1'b0;
    d = bus.dout;
  endtask

  task automatic read_char(input string name, input int budget, output logic [7:0] d,
                           output int waited);
    logic [7:0] s;
    bit got;
    got = 1'b0; waited = 0; d = 8'h00;
    while (!got && waited < budget) begin
      bus_rd(1'b1, s);
      waited++;
      if (s[7]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s ready_timeout waited=%0d limit=%0d", name, waited, budget);
    end else begin
      bus_rd(1'b0, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete(); last_cr = '0; model_rr = 0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    exp_q.delete(); last_cr = '0;
    tick(1);
    bus.flush = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin : main
    logic [7:0] d;
    int w;
    logic [7:0] t2_exp [6];
    int iter;

    t2_exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB1, 8'hB2, 8'hB3};
    rst = 1'b0; bus.flush = 1'b0; bus.cs = 1'b0; bus.enable = 1'b0; bus.we = 1'b0;
    bus.address = 1'b0; gap_en = 1'b0; acc_cnt = 0; model_rr = 0; last_cr = '0;
    #5 rst = 1'b1;

    // Reset state with a source already presenting a byte
    src_q[0].push_back(8'h61);
    tick(3);
    check("rst_src_ready", 32'(bus.src_ready), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    rst = 1'b0;

    // Single lower-case byte
    read_char("t1_ready", 5, d, w);
    check("t1_kbd", 32'(d), 32'hC1);
    bus_rd(1'b1, d);
    check("t1_kbdcr_after", 32'(d), 32'h00);

    // Three continuously valid sources share round-robin
    do_reset();
    for (int r = 0; r < 2; r++) begin
      src_q[0].push_back(8'h31); src_q[1].push_back(8'h32); src_q[2].push_back(8'h33);
    end
    for (int n = 0; n < 6; n++) begin
      read_char("t2_ready", 8, d, w);
      check("t2_order", 32'(d), 32'(t2_exp[n]));
    end

    // CR LF LF with pacing after the consumed CR
    do_reset();
    src_q[1].push_back(8'h0D); src_q[1].push_back(8'h0A); src_q[1].push_back(8'h0A);
    read_char("t3_ready1", 6, d, w);
    check("t3_cr1", 32'(d), 32'h8D);
    read_char("t3_ready2", 60, d, w);
    check("t3_pace_hold", 32'(w >= PACE), 32'd1);
    check("t3_cr2", 32'(d), 32'h8D);
    tick(3);
    bus_rd(1'b1, d);
    check("t3_kbdcr_empty", 32'(d), 32'h00);

    // Fill FIFO and holding register with no CPU reads
    do_reset();
    acc_cnt = 0;
    for (int n = 0; n < DEPTH + 2; n++) src_q[0].push_back(8'h61 + 8'($urandom_range(0, 25)));
    tick(DEPTH + 10);
    check("t4_level_full", 32'(bus.fifo_level), DEPTH);
    check("t4_accepted", acc_cnt, DEPTH + 1);
    check("t4_ready_held", 32'(bus.src_ready), 32'd0);
    check("t4_overflow", 32'(bus.overflow), 32'd0);
    bus_rd(1'b1, d);
    check("t4_kbdcr", 32'(d), 32'h80);
    bus_rd(1'b0, d);
    tick(4);
    check("t4_one_more", acc_cnt, DEPTH + 2);
    check("t4_level_refill", 32'(bus.fifo_level), DEPTH);
    for (int n = 0; n < DEPTH + 1; n++) read_char("t4_drain", 6, d, w);
    check("t4_level_empty", 32'(bus.fifo_level), 32'd0);
    check("t4_overflow_end", 32'(bus.overflow), 32'd0);

    // Flush with queued bytes and ready set, then flush mid-pace
    do_reset();
    for (int n = 0; n < 6; n++) src_q[2].push_back(8'h41 + 8'(n));
    tick(12);
    check("t5_level_pre", 32'(bus.fifo_level), 32'd5);
    bus_rd(1'b1, d);
    check("t5_kbdcr_pre", 32'(d), 32'h80);
    do_flush();
    check("t5_level_post", 32'(bus.fifo_level), 32'd0);
    bus_rd(1'b1, d);
    check("t5_kbdcr_post", 32'(d), 32'h00);
    src_q[2].push_back(8'h0D); src_q[2].push_back(8'h78); src_q[2].push_back(8'h79);
    read_char("t5_cr_ready", 6, d, w);
    check("t5_cr", 32'(d), 32'h8D);
    tick(1);
    do_flush();
    src_q[2].push_back(8'h0A);
    read_char("t5_unpaced", 6, d, w);
    check("t5_lf_after_flush", 32'(d), 32'h8D);

    // Asynchronous reset in the middle of a pace interval
    do_reset();
    src_q[0].push_back(8'h0D); src_q[0].push_back(8'h62);
    read_char("t6_cr_ready", 6, d, w);
    check("t6_cr", 32'(d), 32'h8D);
    tick(3);
    #3;
    rst = 1'b1;
    exp_q.delete(); last_cr = '0; model_rr = 0;
    src_q[1].push_back(8'h7A);
    #1;
    check("t6_rst_dout", 32'(bus.dout), 32'h00);
    check("t6_rst_level", 32'(bus.fifo_level), 32'd0);
    check("t6_rst_overflow", 32'(bus.overflow), 32'd0);
    tick(2);
    check("t6_rst_src_ready", 32'(bus.src_ready), 32'd0);
    rst = 1'b0;
    read_char("t6_unpaced", 6, d, w);
    check("t6_new_byte", 32'(d), 32'hDA);

    // Random mixed traffic on all sources with idle gaps
    do_reset();
    gap_en = 1'b1;
    for (int n = 0; n < 45; n++) begin
      int s;
      int r;
      logic [7:0] b;
      s = $urandom_range(0, NS - 1);
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'h0D;
      else if (r == 1) b = 8'h0A;
      else if (r == 2) b = 8'h61 + 8'($urandom_range(0, 25));
      else             b = 8'($urandom_range(0, 255));
      src_q[s].push_back(b);
    end
    iter = 0;
    while ((exp_q.size() > 0 || pending() > 0) && iter < 400) begin
      iter++;
      if (exp_q.size() == 0) tick(1);
      else begin
        read_char("rand_ready", 80, d, w);
        tick($urandom_range(0, 3) + 1);
      end
    end
    check("rand_drained", 32'(exp_q.size() + pending()), 32'd0);
    check("rand_overflow", 32'(bus.overflow), 32'd0);
    tick(2);
    check("rand_level", 32'(bus.fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
